// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: funct3 size codes, FSM states,
// byte width and the access legality check.
package load_store_unit_pkg;

    localparam int BYTE_W = 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    // Misaligned halfword/word, unknown size code, or a store with an unsigned size.
    function automatic logic access_err(input logic store, input logic [2:0] funct3,
                                        input logic [1:0] off);
        logic err;
        case (funct3)
            F3_B:    err = 1'b0;
            F3_H:    err = off[0];
            F3_W:    err = (off != 2'b00);
            F3_BU:   err = store;
            F3_HU:   err = store | off[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response handshake of the load/store unit.
interface load_store_unit_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/load_store_unit_align.sv
// Combinational lane steering: store byte enables / replicated write data and
// load lane extraction with sign or zero extension.
module lsu_align
    import load_store_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rword,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wlane,
    output logic [XLEN-1:0] rext
);
    logic [XLEN-1:0] shifted;

    always_comb begin
        be      = 4'b0000;
        wlane   = wdata;
        shifted = rword >> {off, 3'b000};
        rext    = shifted;
        case (funct3)
            F3_B: begin
                be    = 4'b0001 << off;
                wlane = {(XLEN/BYTE_W){wdata[BYTE_W-1:0]}};
                rext  = {{(XLEN-BYTE_W){shifted[BYTE_W-1]}}, shifted[BYTE_W-1:0]};
            end
            F3_H: begin
                be    = 4'b0011 << off;
                wlane = {(XLEN/(2*BYTE_W)){wdata[2*BYTE_W-1:0]}};
                rext  = {{(XLEN-2*BYTE_W){shifted[2*BYTE_W-1]}}, shifted[2*BYTE_W-1:0]};
            end
            F3_W:  be   = 4'b1111;
            F3_BU: rext = {{(XLEN-BYTE_W){1'b0}}, shifted[BYTE_W-1:0]};
            F3_HU: rext = {{(XLEN-2*BYTE_W){1'b0}}, shifted[2*BYTE_W-1:0]};
            default: ;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the core handshake and a
// word-wide dmem with registered read data.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int DMEM_AW = 10,
    parameter int XLEN    = 32
) (
    input  logic               clk,
    input  logic               reset,
    load_store_unit_if.slave   core,
    output logic [DMEM_AW-1:0] daddr,
    output logic [3:0]         we,
    output logic [XLEN-1:0]    indata,
    input  logic [XLEN-1:0]    outdata
);
    state_e               state;
    logic [DMEM_AW+1:0]   addr_q;   // only the bits that reach dmem are kept
    logic [2:0]           funct3_q;
    logic                 we_q;
    logic [XLEN-1:0]      wdata_q;
    logic [XLEN-1:0]      rdata_q;
    logic                 err_q;

    logic [3:0]           be;
    logic [XLEN-1:0]      wlane;
    logic [XLEN-1:0]      rext;

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3 (funct3_q),
        .off    (addr_q[1:0]),
        .wdata  (wdata_q),
        .rword  (outdata),
        .be     (be),
        .wlane  (wlane),
        .rext   (rext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (core.req_valid) begin
                    addr_q   <= core.req_addr[DMEM_AW+1:0];
                    funct3_q <= core.req_funct3;
                    we_q     <= core.req_we;
                    wdata_q  <= core.req_wdata;
                    rdata_q  <= '0;
                    err_q    <= access_err(core.req_we, core.req_funct3, core.req_addr[1:0]);
                    state    <= access_err(core.req_we, core.req_funct3, core.req_addr[1:0])
                                ? S_RESP : S_ISSUE;
                end
                S_ISSUE: state <= we_q ? S_RESP : S_WAIT;
                S_WAIT: begin
                    rdata_q <= rext;
                    state   <= S_RESP;
                end
                S_RESP: if (core.resp_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign core.req_ready  = (state == S_IDLE);
    assign core.resp_valid = (state == S_RESP);
    assign core.resp_rdata = rdata_q;
    assign core.resp_err   = err_q;

    // Gating with reset keeps an aborted store from writing on the reset edge.
    assign daddr  = addr_q[DMEM_AW+1:2];
    assign we     = (state == S_ISSUE && we_q && !reset) ? be : 4'b0000;
    assign indata = wlane;
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DMEM_AW, default 10: dmem word-address width; must equal `dmem_addr.
REQ-002 SHALL have parameter XLEN, default 32: data and byte-address width; must equal `dmem_width.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock shared with dmem.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 req_valid  input  1  core presents an access.
REQ-007 req_ready  output  1  unit accepts an access.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_funct3  input  3  size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 req_addr  input  XLEN  byte address.
REQ-011 req_wdata  input  XLEN  store data, right-aligned.
REQ-012 resp_valid  output  1  response available.
REQ-013 resp_ready  input  1  core consumes the response.
REQ-014 resp_rdata  output  XLEN  extended load data; 0 for stores and errors.
REQ-015 resp_err  output  1  misaligned access or illegal funct3.
REQ-016 daddr  output  DMEM_AW  dmem word address.
REQ-017 we  output  4  dmem per-byte write enables.
REQ-018 indata  output  XLEN  dmem write data.
REQ-019 outdata  input  XLEN  dmem registered read data.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-021 SHALL drive req_ready = 1 only in IDLE.
REQ-022 On a handshake (req_valid & req_ready), SHALL register addr, funct3, we and wdata.
REQ-023 On handshake, a legal access SHALL go IDLE->ISSUE; an error access SHALL go IDLE->RESP with resp_err = 1 and no dmem write.
REQ-024 Error conditions: H/HU with addr[0] = 1; W with addr[1:0] != 0; funct3 in {011, 110, 111}; store with funct3 100 or 101.
REQ-025 daddr SHALL equal registered addr[DMEM_AW+1:2]; higher address bits are ignored, so addresses wrap modulo the dmem size.
REQ-026 daddr SHALL stay constant from ISSUE through the end of RESP.
REQ-027 we SHALL be 0000 in every state except ISSUE of a store, and whenever reset = 1.
REQ-028 Store enables: B -> 0001 << addr[1:0]; H -> 0011 << addr[1:0]; W -> 1111.
REQ-029 Store data: B -> the byte replicated x4; H -> the halfword replicated x2; W -> wdata unchanged.
REQ-030 A store SHALL go ISSUE->RESP.
REQ-031 A load SHALL go ISSUE->WAIT->RESP, registering the formatted outdata into resp_rdata at the end of WAIT.
REQ-032 Load formatting: select lane outdata >> (8*addr[1:0]); B/H sign-extend; BU/HU zero-extend; W passes all 32 bits.
REQ-033 resp_valid SHALL be 1 only in RESP, with resp_rdata and resp_err held stable.
REQ-034 RESP SHALL go to IDLE when resp_ready = 1; otherwise it stays in RESP.
REQ-035 Latency from the handshake edge to resp_valid: store 2 cycles, load 3 cycles, error 1 cycle, assuming resp_ready = 1.
REQ-036 No new request SHALL be accepted in the cycle in which RESP retires; throughput is at most one access per 3 cycles.

Reset
REQ-037 On reset: state = IDLE, resp_valid = 0, resp_err = 0, resp_rdata = 0, and all registered request fields = 0.
REQ-038 Reset asserted in any state, including mid-store ISSUE, SHALL abort the access: no dmem write occurs and the state returns to IDLE on the next cycle.

Structure
REQ-039 funct3 encodings, FSM state encodings and the Byte width SHALL live in the shared parameters.v include.
REQ-040 Store lane/enable generation and load extraction SHALL be a combinational sub-module, lsu_align; the FSM and registers stay in load_store_unit.

Verification
REQ-041 SW addr 0x10, data 0xDEADBEEF -> one ISSUE cycle with we = 1111, daddr = 4, indata = 0xDEADBEEF; resp_valid 2 cycles after the handshake, rdata = 0, err = 0.
REQ-042 SB addr 0x13, data 0x000000A5 -> we = 1000, indata = 0xA5A5A5A5; a subsequent LW addr 0x10 returns 0xA5ADBEEF.
REQ-043 With the word at 0x10 = 0xDEADBEEF -> LB 0x13 = 0xFFFFFFDE; LBU 0x13 = 0x000000DE; LH 0x10 = 0xFFFFBEEF; LHU 0x12 = 0x0000DEAD; each 3 cycles after the handshake.
REQ-044 LW addr 0x12 and SH addr 0x11 -> resp_err = 1 one cycle after the handshake, we = 0000 throughout, rdata = 0.
REQ-045 resp_ready held 0 for 3 cycles in RESP -> resp_valid, resp_rdata and daddr stable; req_ready = 0.
REQ-046 Reset during ISSUE of SW 0x12345678 to 0x10 -> we = 0000 that cycle, state IDLE next cycle, and a later LW 0x10 returns the old word.
